// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned MAX_BW = 128;

    // Tail keep mask: low 'rem' lanes set, or all 'bw' lanes when rem is 0.
    function automatic logic [MAX_BW-1:0] keep_from_rem(input int unsigned rem,
                                                        input int unsigned bw);
        logic [MAX_BW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BW; i++) begin
            if (i < bw && (rem == 0 || i < rem)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_pkt_beat_fmt.sv
// Combinational beat formatter: builds tdata/tkeep/tlast for one beat from
// the pattern seed, packet index, byte offset and bytes still to send.
module axis_pkt_beat_fmt
    import axis_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic [7:0]          seed,
    input  logic [7:0]          pkt_idx,
    input  logic [LEN_W-1:0]    byte_off,
    input  logic [LEN_W-1:0]    rem,
    output logic [DATA_W-1:0]   tdata,
    output logic [DATA_W/8-1:0] tkeep,
    output logic                tlast
);

    localparam int unsigned BW = DATA_W / 8;

    logic [7:0]        base;
    logic [MAX_BW-1:0] mask;

    always_comb begin
        base  = seed + pkt_idx + 8'(byte_off);
        tlast = (rem <= LEN_W'(BW));
        mask  = keep_from_rem(tlast ? (32'(rem) % BW) : 32'd0, BW);
        tkeep = mask[BW-1:0];
        tdata = '0;
        // Lanes past the end of the packet stay zero.
        for (int i = 0; i < int'(BW); i++) begin
            if (tkeep[i]) tdata[8*i +: 8] = base + 8'(i);
        end
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: configurable length/count/gap runs with a
// deterministic byte pattern and SOF on tuser[0].
module axis_pkt_gen
    import axis_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DATA_BW = DATA_W / 8,
    parameter int KEEP_W  = DATA_BW,
    parameter int ID_W    = 1,
    parameter int DEST_W  = 1,
    parameter int USER_W  = 1,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int GAP_W   = 8
) (
    input  logic              m_axis_clk,
    input  logic              m_axis_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_num_pkts,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [7:0]        cfg_seed,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [DEST_W-1:0] cfg_dest,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tstrb,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [DEST_W-1:0] m_axis_tdest,
    output logic [USER_W-1:0] m_axis_tuser
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         seed_q, seed_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DEST_W-1:0]  dest_q, dest_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [LEN_W-1:0]   off_q, off_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tvalid_q, tvalid_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic [KEEP_W-1:0]  tkeep_q, tkeep_d;
    logic               tlast_q, tlast_d;
    logic               sof_q, sof_d;

    logic               fire, load, clear;
    logic [CNT_W-1:0]   cnt_inc;
    logic [7:0]         fmt_seed, fmt_pkt;
    logic [LEN_W-1:0]   fmt_off, fmt_len, fmt_rem;
    logic [DATA_W-1:0]  fmt_data;
    logic [KEEP_W-1:0]  fmt_keep;
    logic               fmt_last;

    axis_pkt_beat_fmt #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_fmt (
        .seed     (fmt_seed),
        .pkt_idx  (fmt_pkt),
        .byte_off (fmt_off),
        .rem      (fmt_rem),
        .tdata    (fmt_data),
        .tkeep    (fmt_keep),
        .tlast    (fmt_last)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        num_d     = num_q;
        gap_d     = gap_q;
        seed_d    = seed_q;
        id_d      = id_q;
        dest_d    = dest_q;
        pkt_cnt_d = pkt_cnt_q;
        off_d     = off_q;
        gap_cnt_d = gap_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        sof_d     = sof_q;

        fire      = tvalid_q & m_axis_tready;
        cnt_inc   = pkt_cnt_q + CNT_W'(1);
        load      = 1'b0;
        clear     = 1'b0;
        fmt_seed  = seed_q;
        fmt_pkt   = 8'(pkt_cnt_q);
        fmt_off   = '0;
        fmt_len   = len_q;

        case (state_q)
            IDLE: begin
                if (start && cfg_len != '0) begin
                    len_d     = cfg_len;
                    num_d     = cfg_num_pkts;
                    gap_d     = cfg_gap;
                    seed_d    = cfg_seed;
                    id_d      = cfg_id;
                    dest_d    = cfg_dest;
                    pkt_cnt_d = '0;
                    off_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                    fmt_seed  = cfg_seed;
                    fmt_pkt   = 8'd0;
                    fmt_len   = cfg_len;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (fire) begin
                    if (!tlast_q) begin
                        off_d   = off_q + LEN_W'(DATA_BW);
                        fmt_off = off_q + LEN_W'(DATA_BW);
                        load    = 1'b1;
                    end else begin
                        pkt_cnt_d = cnt_inc;
                        off_d     = '0;
                        if ((num_q != '0 && cnt_inc == num_q) || stop) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            clear   = 1'b1;
                        end else if (gap_q == '0) begin
                            fmt_pkt = 8'(cnt_inc);
                            load    = 1'b1;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                            clear     = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    // Load on the last idle cycle so tvalid rises right after it.
                    state_d = SEND;
                    load    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        fmt_rem = fmt_len - fmt_off;

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = fmt_data;
            tkeep_d  = fmt_keep;
            tlast_d  = fmt_last;
            sof_d    = (fmt_off == '0);
        end else if (clear) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            sof_d    = 1'b0;
        end
    end

    always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
        if (!m_axis_rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            seed_q    <= '0;
            id_q      <= '0;
            dest_q    <= '0;
            pkt_cnt_q <= '0;
            off_q     <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            sof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            num_q     <= num_d;
            gap_q     <= gap_d;
            seed_q    <= seed_d;
            id_q      <= id_d;
            dest_q    <= dest_d;
            pkt_cnt_q <= pkt_cnt_d;
            off_q     <= off_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tlast_q   <= tlast_d;
            sof_q     <= sof_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tstrb  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = id_q;
    assign m_axis_tdest  = dest_q;
    assign m_axis_tuser  = USER_W'(sof_q);

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- Single-clock AXI4-Stream packet generator (transmitter) that drives the slave side of the async AXIS FIFO wrapper for bring-up, loopback and throughput testing.
- Emits a configurable number of packets with byte-accurate length, a deterministic byte pattern, an SOF flag on tuser, and programmable inter-packet gaps.
- Obeys full AXIS valid/ready rules under arbitrary backpressure.

Parameters:
- DATA_W, 32, tdata width in bits; multiple of 8.
- DATA_BW, DATA_W/8, bytes per beat.
- KEEP_W, DATA_BW, tkeep/tstrb width.
- ID_W, 1, tid width.
- DEST_W, 1, tdest width.
- USER_W, 1, tuser width; bit 0 = SOF.
- LEN_W, 16, width of the packet byte-length config.
- CNT_W, 16, width of the packet count config and counter.
- GAP_W, 8, width of the inter-packet gap config.

Ports:
- m_axis_clk  in  1  clock
- m_axis_rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; latches cfg_* and begins a run
- stop  in  1  level; ends the run at the next packet boundary
- cfg_len  in  LEN_W  packet length in bytes
- cfg_num_pkts  in  CNT_W  packets per run; 0 = unlimited
- cfg_gap  in  GAP_W  idle cycles between packets
- cfg_seed  in  8  pattern seed
- cfg_id  in  ID_W  tid value
- cfg_dest  in  DEST_W  tdest value
- busy  out  1  run in progress
- done  out  1  1-cycle pulse at run end
- pkt_cnt  out  CNT_W  packets completed in the current/last run
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tdata  out  DATA_W
- m_axis_tstrb  out  KEEP_W
- m_axis_tkeep  out  KEEP_W
- m_axis_tlast  out  1
- m_axis_tid  out  ID_W
- m_axis_tdest  out  DEST_W
- m_axis_tuser  out  USER_W

Behaviour:
- Reset (async assert, sync deassert by the system): all outputs 0; FSM = IDLE; counters 0.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - On start with cfg_len != 0: latch all cfg_*, clear pkt_cnt, set busy, go to SEND.
  - The first beat is presented registered with tvalid=1 on the cycle after start.
  - start with cfg_len == 0 is ignored.
  - start while busy is ignored.
- Beat count = ceil(len/DATA_BW).
  - Byte b of packet p (0-based within the run) = (seed + p + b) mod 256, byte 0 in lane 0 (LSBs).
  - Final beat: tkeep = low (len mod DATA_BW) bits set, or all ones if the remainder is 0. Lanes beyond len carry tdata = 0.
  - tstrb = tkeep.
  - tuser[0] = 1 on the first beat only; tuser[USER_W-1:1] = 0.
  - tid/tdest = latched values.
- Handshake:
  - A beat completes when tvalid & tready.
  - All m_axis outputs hold stable while tvalid & !tready.
  - Once asserted, tvalid never drops before the handshake.
  - The next beat is loaded on the same cycle as the handshake, so tready held high gives 1 beat/cycle.
- On the last-beat handshake, pkt_cnt increments, then:
  - If num_pkts != 0 and the new pkt_cnt == num_pkts, or stop is high: go to IDLE, drop tvalid, clear busy, pulse done next cycle.
  - Else if gap == 0: go to SEND back-to-back with no bubble.
  - Else: go to GAP with tvalid=0 for exactly gap cycles, then SEND.
- stop:
  - Never truncates a packet.
  - Sampled at the last-beat handshake, and in every GAP cycle.
  - High in GAP: go to IDLE immediately and pulse done.
- pkt_cnt wraps modulo 2^CNT_W when num_pkts = 0. Pattern arithmetic is 8-bit wrap.
- Reset mid-packet: outputs clear immediately (async). No partial state survives.

Decomposition:
- Shared package axis_pkg: state enum (IDLE/SEND/GAP) and a function keep_from_rem(rem, DATA_BW) returning the tail tkeep mask.
- One sub-module, axis_pkt_beat_fmt: combinational beat formatter. Inputs: seed, pkt index, byte offset, remaining bytes. Outputs: tdata, tkeep, tlast.
- The FSM, counters and output registers live in axis_pkt_gen.

Test Plan:
- Basic single packet. DATA_W=32, len=6, num=1, seed=0x10, gap=0, tready=1, start at cycle 0.
  - Cycle 1: tdata=0x13121110, tkeep=0xF, tuser=1, tlast=0.
  - Cycle 2: tdata=0x00001514, tkeep=0x3, tlast=1.
  - Cycle 3: done=1, busy=0, pkt_cnt=1.
- Backpressure. Same config with tready toggling 1,0,0,1.
  - Beat 0 is held unchanged across both stalled cycles.
  - Exactly 2 handshakes occur; no duplicate or lost beat.
- Gap timing. len=4, num=3, gap=2.
  - Three single-beat packets with tlast=1 and tuser=1.
  - tdata LSB bytes 0x10, 0x11, 0x12.
  - Exactly 2 tvalid=0 cycles between packets; pkt_cnt=3 at done.
- Stop boundary. num=0, len=12 (3 beats), stop raised during beat 1.
  - Packet completes through its tlast beat, then IDLE with a done pulse.
  - No further tvalid.
- Ignored and reset cases:
  - start with cfg_len=0: busy stays 0 and no tvalid.
  - m_axis_rst_n asserted mid-packet: tvalid/busy/pkt_cnt read 0 in the same cycle, FSM = IDLE.
  - A start after release produces a fresh packet beginning with SOF.
